tofpet_cfg_shifter: RTL and testbench
=====================================

// Module: tofpet_cfg_shifter
// PURPOSE
//  Serial configuration engine between the Avalon control FIFOs/registers and the TOFPET ASIC config port.
//  Pops 32-bit words from the TX control FIFO and shifts NBIT bits MSB-first on SDI/SCLK under CS_N.
//  Captures SDO into 32-bit words pushed to the RX control FIFO; reports progress on STATUS_WORD.
// PARAMETERS
//  CLK_DIV    4  SCLK half-period in CK cycles (>=2)
//  SETUP_CYC  2  CK cycles from CS_N fall to first SCLK rise phase
//  HOLD_CYC   2  CK cycles from last SCLK fall to CS_N rise
// PORTS
//  CK            in   1   system clock, 100 MHz
//  RESETb        in   1   asynchronous active-low reset
//  COMMAND       in   32  [0] START (rising edge), [1] ABORT (level), [2] LOOPBACK (macro only)
//  NBIT_INOUT    in   32  [15:0] bits to transfer; sampled at START
//  TX_DATA       in   32  TX FIFO show-ahead output word
//  TX_EMPTY      in   1   TX FIFO empty
//  TX_RE         out  1   TX FIFO read strobe, 1-cycle pulse
//  RX_DATA       out  32  word to RX FIFO
//  RX_WE         out  1   RX FIFO write strobe, 1-cycle pulse
//  RX_FULL       in   1   RX FIFO full
//  STATUS_WORD   out  32  [0] busy [1] done [2] underflow [3] aborted [4] nbit_zero [31:16] bits shifted
//  SCLK          out  1   ASIC config clock, idle low
//  SDI           out  1   ASIC serial data in (MOSI)
//  SDO           in   1   ASIC serial data out (MISO)
//  CS_N          out  1   ASIC chip select, active low
// BEHAVIOUR
//  Reset: state IDLE; SCLK=0, SDI=0, CS_N=1, TX_RE=0, RX_WE=0, RX_DATA=0, STATUS_WORD=0, counters 0.
//  START = COMMAND[0] high this cycle and low the previous cycle (edge register reset to 0); ignored unless IDLE.
//  FSM: IDLE -> SETUP -> LOAD -> SHIFT_LO <-> SHIFT_HI -> (LOAD | STORE) -> HOLD -> IDLE.
//  IDLE: on START with NBIT[15:0]==0 -> status {done=1, nbit_zero=1}, stay IDLE, CS_N stays 1.
//   Otherwise latch N=NBIT[15:0], clear done/err/abort bits and count, busy=1, CS_N=0, go SETUP.
//  SETUP: wait SETUP_CYC cycles, go LOAD.
//  LOAD: if TX_EMPTY -> underflow=1, go HOLD. Else load TX_DATA into shift reg, pulse TX_RE 1 cycle, go SHIFT_LO.
//  SHIFT_LO: SCLK=0, SDI=shreg[31] driven on entry; lasts CLK_DIV cycles; -> SHIFT_HI.
//  SHIFT_HI: SCLK=1 for CLK_DIV cycles; SDO sampled on last cycle of high phase into rx reg LSB (shift left);
//   count+=1; shreg<<=1. Then: count==N -> STORE(final); 32 bits in word -> STORE; else SHIFT_LO.
//  STORE: wait while RX_FULL (SCLK held low, no bits lost); then RX_WE=1 one cycle with RX_DATA=rx reg.
//   Final partial word: LSB-aligned, upper bits 0. Then final -> HOLD; else -> LOAD.
//  TX words MSB-aligned; final partial TX word uses bits [31:32-rem], low bits discarded (word still popped).
//  HOLD: SCLK=0, wait HOLD_CYC cycles, CS_N=1, busy=0, done=1 (also when underflow/aborted), go IDLE.
//  ABORT: COMMAND[1]=1 in any state but IDLE/HOLD -> aborted=1, partial RX word discarded, go HOLD next cycle.
//   ABORT wins over START and over RX_WE/TX_RE in the same cycle (no strobe issued).
//  STATUS_WORD[31:16] = bits shifted so far, live; saturates never (N<=65535). done/err bits sticky until next START.
//  Words per transfer = ceil(N/32); exactly that many TX_RE and RX_WE pulses on success.
//  SCLK period = 2*CLK_DIV cycles; 100 MHz, CLK_DIV=4 -> 12.5 MHz.
// CONFIGURATION
//  TOFPET_CFG_LOOPBACK_EN defined: COMMAND[2]=1 replaces SDO by internal SDI for sampling (ASIC-less self-test).
//  Not defined: COMMAND[2] ignored, SDO always used; no loopback mux synthesized.
// TESTING
//  N=32, TX word 0xA5A5_0F0F, SDO tied to model echoing SDI -> SDI seq MSB-first, 1 RX_WE, RX_DATA=0xA5A5_0F0F.
//  N=40, TX 0xDEADBEEF,0xFF00_0000, SDO=1 -> 2 TX_RE, RX words 0xFFFFFFFF then 0x000000FF, STATUS[31:16]=40, done=1.
//  N=64, only one word in TX FIFO -> underflow=1, CS_N rises HOLD_CYC after bit 32, done=1, 1 RX_WE.
//  N=64, RX_FULL high at first STORE for 20 cycles -> SCLK held low 20+ cycles, no bit loss, RX data correct.
//  ABORT at bit 10 of N=32 -> aborted=1, no RX_WE, CS_N=1 after HOLD_CYC; START with NBIT=0 -> nbit_zero=1, CS_N stays 1.
//  RESETb low mid-shift -> all outputs to reset values immediately; with TOFPET_CFG_LOOPBACK_EN, COMMAND[2]=1, SDO=0 -> RX equals TX.

Source files
------------

// File: rtl/tofpet_cfg_shifter.sv
// tofpet_cfg_shifter
//   Serial configuration engine for the TOFPET ASIC config port.
//   - Pops 32-bit MSB-aligned words from the TX control FIFO (show-ahead).
//   - Shifts NBIT bits MSB-first on SDI/SCLK while CS_N is low.
//   - Captures SDO into LSB-aligned 32-bit words and pushes them to the RX FIFO.
//   - Reports progress and sticky completion/error flags on STATUS_WORD.
//   Optional build macro TOFPET_CFG_LOOPBACK_EN: COMMAND[2]=1 samples the
//   internally driven SDI instead of SDO (ASIC-less self-test). Without the
//   macro COMMAND[2] is ignored and no loopback mux exists.
module tofpet_cfg_shifter #(
  parameter int CLK_DIV   = 4,  // SCLK half-period in CK cycles (>=2)
  parameter int SETUP_CYC = 2,  // CS_N fall to first shift phase
  parameter int HOLD_CYC  = 2   // last SCLK fall to CS_N rise
) (
  input  logic        CK,
  input  logic        RESETb,
  input  logic [31:0] COMMAND,
  input  logic [31:0] NBIT_INOUT,
  input  logic [31:0] TX_DATA,
  input  logic        TX_EMPTY,
  output logic        TX_RE,
  output logic [31:0] RX_DATA,
  output logic        RX_WE,
  input  logic        RX_FULL,
  output logic [31:0] STATUS_WORD,
  output logic        SCLK,
  output logic        SDI,
  input  logic        SDO,
  output logic        CS_N
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOAD,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_STORE,
    S_HOLD
  } state_t;

  // Terminal values of the shared phase counter (a zero count still takes one cycle)
  localparam logic [15:0] DIV_LAST   = 16'((CLK_DIV   > 1) ? CLK_DIV   - 1 : 0);
  localparam logic [15:0] SETUP_LAST = 16'((SETUP_CYC > 1) ? SETUP_CYC - 1 : 0);
  localparam logic [15:0] HOLD_LAST  = 16'((HOLD_CYC  > 1) ? HOLD_CYC  - 1 : 0);

  state_t      state_reg;
  logic        start_prev_reg;
  logic [15:0] cyc_cnt_reg;
  logic [15:0] nbit_reg;
  logic [15:0] bit_cnt_reg;
  logic [5:0]  word_bits_reg;
  logic [31:0] tx_shreg_reg;
  logic [31:0] rx_shreg_reg;
  logic        final_word_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        underflow_reg;
  logic        aborted_reg;
  logic        nbit_zero_reg;

  logic        start_pulse;
  logic        abort_req;
  logic        sample_bit;
  logic [15:0] bit_cnt_next;
  logic [5:0]  word_bits_next;
  logic        unused_inputs;

  // Rising edge of COMMAND[0] is the START request
  assign start_pulse = COMMAND[0] & ~start_prev_reg;

  // ABORT only matters while a transfer is actually in progress
  assign abort_req = COMMAND[1] && (state_reg != S_IDLE) && (state_reg != S_HOLD);

  assign bit_cnt_next   = bit_cnt_reg + 16'd1;
  assign word_bits_next = word_bits_reg + 6'd1;

`ifdef TOFPET_CFG_LOOPBACK_EN
  // Loopback: sample our own SDI so the datapath can be tested without an ASIC
  assign sample_bit    = COMMAND[2] ? SDI : SDO;
  assign unused_inputs = ^{COMMAND[31:3], NBIT_INOUT[31:16]};
`else
  assign sample_bit    = SDO;
  assign unused_inputs = ^{COMMAND[31:2], NBIT_INOUT[31:16]};
`endif

  // Status is a live view of the registered flags and bit counter
  assign STATUS_WORD = {bit_cnt_reg, 11'd0, nbit_zero_reg, aborted_reg,
                        underflow_reg, done_reg, busy_reg};

  // Main transfer FSM; every port output is a register written here
  always_ff @(posedge CK or negedge RESETb) begin
    if (!RESETb) begin
      state_reg      <= S_IDLE;
      start_prev_reg <= 1'b0;
      cyc_cnt_reg    <= 16'd0;
      nbit_reg       <= 16'd0;
      bit_cnt_reg    <= 16'd0;
      word_bits_reg  <= 6'd0;
      tx_shreg_reg   <= 32'd0;
      rx_shreg_reg   <= 32'd0;
      final_word_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      underflow_reg  <= 1'b0;
      aborted_reg    <= 1'b0;
      nbit_zero_reg  <= 1'b0;
      SCLK           <= 1'b0;
      SDI            <= 1'b0;
      CS_N           <= 1'b1;
      TX_RE          <= 1'b0;
      RX_WE          <= 1'b0;
      RX_DATA        <= 32'd0;
    end else begin
      start_prev_reg <= COMMAND[0];
      TX_RE          <= 1'b0;
      RX_WE          <= 1'b0;

      if (abort_req) begin
        // Abort beats any strobe due this cycle; partial RX word is dropped
        aborted_reg   <= 1'b1;
        rx_shreg_reg  <= 32'd0;
        word_bits_reg <= 6'd0;
        SCLK          <= 1'b0;
        SDI           <= 1'b0;
        cyc_cnt_reg   <= 16'd0;
        state_reg     <= S_HOLD;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (start_pulse) begin
              if (NBIT_INOUT[15:0] == 16'd0) begin
                // Nothing to shift: report immediately, chip select untouched
                done_reg      <= 1'b1;
                nbit_zero_reg <= 1'b1;
                underflow_reg <= 1'b0;
                aborted_reg   <= 1'b0;
                bit_cnt_reg   <= 16'd0;
              end else begin
                nbit_reg       <= NBIT_INOUT[15:0];
                bit_cnt_reg    <= 16'd0;
                word_bits_reg  <= 6'd0;
                rx_shreg_reg   <= 32'd0;
                final_word_reg <= 1'b0;
                done_reg       <= 1'b0;
                underflow_reg  <= 1'b0;
                aborted_reg    <= 1'b0;
                nbit_zero_reg  <= 1'b0;
                busy_reg       <= 1'b1;
                CS_N           <= 1'b0;
                cyc_cnt_reg    <= 16'd0;
                state_reg      <= S_SETUP;
              end
            end
          end

          S_SETUP: begin
            if (cyc_cnt_reg == SETUP_LAST) begin
              cyc_cnt_reg <= 16'd0;
              state_reg   <= S_LOAD;
            end else begin
              cyc_cnt_reg <= cyc_cnt_reg + 16'd1;
            end
          end

          S_LOAD: begin
            if (TX_EMPTY) begin
              underflow_reg <= 1'b1;
              SDI           <= 1'b0;
              cyc_cnt_reg   <= 16'd0;
              state_reg     <= S_HOLD;
            end else begin
              // First data bit goes out together with the low phase
              tx_shreg_reg <= TX_DATA;
              SDI          <= TX_DATA[31];
              SCLK         <= 1'b0;
              TX_RE        <= 1'b1;
              cyc_cnt_reg  <= 16'd0;
              state_reg    <= S_SHIFT_LO;
            end
          end

          S_SHIFT_LO: begin
            if (cyc_cnt_reg == DIV_LAST) begin
              SCLK        <= 1'b1;
              cyc_cnt_reg <= 16'd0;
              state_reg   <= S_SHIFT_HI;
            end else begin
              cyc_cnt_reg <= cyc_cnt_reg + 16'd1;
            end
          end

          S_SHIFT_HI: begin
            if (cyc_cnt_reg == DIV_LAST) begin
              // SDO is taken at the end of the high phase, just before the fall
              rx_shreg_reg  <= {rx_shreg_reg[30:0], sample_bit};
              tx_shreg_reg  <= {tx_shreg_reg[30:0], 1'b0};
              bit_cnt_reg   <= bit_cnt_next;
              word_bits_reg <= word_bits_next;
              SCLK          <= 1'b0;
              cyc_cnt_reg   <= 16'd0;
              if (bit_cnt_next == nbit_reg) begin
                final_word_reg <= 1'b1;
                state_reg      <= S_STORE;
              end else if (word_bits_next == 6'd32) begin
                state_reg <= S_STORE;
              end else begin
                SDI       <= tx_shreg_reg[30];
                state_reg <= S_SHIFT_LO;
              end
            end else begin
              cyc_cnt_reg <= cyc_cnt_reg + 16'd1;
            end
          end

          S_STORE: begin
            // SCLK stays low while the RX FIFO is full, so no bit is lost
            SCLK <= 1'b0;
            if (!RX_FULL) begin
              RX_WE         <= 1'b1;
              RX_DATA       <= rx_shreg_reg;
              rx_shreg_reg  <= 32'd0;
              word_bits_reg <= 6'd0;
              cyc_cnt_reg   <= 16'd0;
              if (final_word_reg) begin
                SDI       <= 1'b0;
                state_reg <= S_HOLD;
              end else begin
                state_reg <= S_LOAD;
              end
            end
          end

          S_HOLD: begin
            SCLK <= 1'b0;
            if (cyc_cnt_reg == HOLD_LAST) begin
              // Every exit path ends here, so done also flags error/abort endings
              CS_N        <= 1'b1;
              busy_reg    <= 1'b0;
              done_reg    <= 1'b1;
              cyc_cnt_reg <= 16'd0;
              state_reg   <= S_IDLE;
            end else begin
              cyc_cnt_reg <= cyc_cnt_reg + 16'd1;
            end
          end

          default: begin
            state_reg <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tofpet_cfg_shifter.sv
// tb_tofpet_cfg_shifter
//   Table of transfer vectors plus hand-built sequences for RX back-pressure,
//   abort, reset mid-shift and (when TOFPET_CFG_LOOPBACK_EN is defined) loopback.
//   Expected RX words go into a queue when a transfer is set up and are popped
//   by the monitor whenever the DUT writes the RX FIFO.
module tb_tofpet_cfg_shifter;

  logic        CK = 1'b0;
  logic        RESETb = 1'b0;
  logic [31:0] COMMAND = 32'd0;
  logic [31:0] NBIT_INOUT = 32'd0;
  logic [31:0] TX_DATA = 32'd0;
  logic        TX_EMPTY = 1'b1;
  logic        TX_RE;
  logic [31:0] RX_DATA;
  logic        RX_WE;
  logic        RX_FULL = 1'b0;
  logic [31:0] STATUS_WORD;
  logic        SCLK;
  logic        SDI;
  logic        SDO;
  logic        CS_N;

  tofpet_cfg_shifter #(.CLK_DIV(4), .SETUP_CYC(2), .HOLD_CYC(2)) dut (
    .CK(CK), .RESETb(RESETb), .COMMAND(COMMAND), .NBIT_INOUT(NBIT_INOUT),
    .TX_DATA(TX_DATA), .TX_EMPTY(TX_EMPTY), .TX_RE(TX_RE),
    .RX_DATA(RX_DATA), .RX_WE(RX_WE), .RX_FULL(RX_FULL),
    .STATUS_WORD(STATUS_WORD), .SCLK(SCLK), .SDI(SDI), .SDO(SDO), .CS_N(CS_N)
  );

  always #5 CK = ~CK;

  int n_cmp = 0;
  int n_bad = 0;
  int tx_re_cnt = 0;
  int rx_we_cnt = 0;
  int cs_low_cnt = 0;
  int sdo_mode = 0;          // 0: SDO low, 1: SDO high, 2: ASIC echoes SDI
  logic [31:0] tx_q[$];
  logic [31:0] exp_q[$];

  // ASIC model for SDO
  always @* SDO = (sdo_mode == 2) ? SDI : (sdo_mode == 1);

  typedef struct {
    logic [15:0] nbit;
    int          nwords;
    logic [31:0] w0;
    logic [31:0] w1;
    int          sdo;
    int          exp_nrx;
    logic [31:0] r0;
    logic [31:0] r1;
    int          exp_tx_re;
    logic [31:0] exp_status;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  // TX FIFO model, RX scoreboard and chip-select monitor, away from the active edge
  always @(negedge CK) begin
    logic [31:0] e;
    if (RESETb && TX_RE) begin
      tx_re_cnt++;
      if (tx_q.size() > 0) e = tx_q.pop_front();
    end
    if (RESETb && RX_WE) begin
      rx_we_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rx_word: got %h expected none", RX_DATA);
      end else begin
        e = exp_q.pop_front();
        if (RX_DATA !== e) begin
          n_bad++;
          $display("FAIL rx_word: got %h expected %h", RX_DATA, e);
        end else begin
          $display("ok   rx_word: %h", RX_DATA);
        end
      end
    end
    if (CS_N === 1'b0) cs_low_cnt++;
    TX_EMPTY = (tx_q.size() == 0);
    TX_DATA  = (tx_q.size() == 0) ? 32'd0 : tx_q[0];
  end

  task automatic start_xfer(input logic [15:0] n);
    NBIT_INOUT = {16'd0, n};
    @(posedge CK); #1;
    COMMAND[0] = 1'b1;
    @(posedge CK); #1;
    COMMAND[0] = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (STATUS_WORD[0] === 1'b1 && k < 3000) begin
      @(posedge CK); #1;
      k++;
    end
    if (k >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: busy still %b after %0d cycles", nm, STATUS_WORD[0], k);
    end
  endtask

  task automatic wait_count(input string nm, input logic [15:0] cnt);
    int k;
    k = 0;
    while (STATUS_WORD[31:16] !== cnt && k < 3000) begin
      @(posedge CK); #1;
      k++;
    end
    if (k >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: bit count %0d never reached %0d", nm, STATUS_WORD[31:16], cnt);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    tx_re_cnt = 0; rx_we_cnt = 0; cs_low_cnt = 0;
    sdo_mode = v.sdo;
    if (v.nwords > 0) tx_q.push_back(v.w0);
    if (v.nwords > 1) tx_q.push_back(v.w1);
    if (v.exp_nrx > 0) exp_q.push_back(v.r0);
    if (v.exp_nrx > 1) exp_q.push_back(v.r1);
    repeat (2) @(posedge CK);
    #1;
    start_xfer(v.nbit);
    wait_idle(tag);
    check({tag, "_status"}, STATUS_WORD, v.exp_status);
    check({tag, "_tx_re"}, 32'(tx_re_cnt), 32'(v.exp_tx_re));
    check({tag, "_rx_we"}, 32'(rx_we_cnt), 32'(v.exp_nrx));
    check({tag, "_rx_pending"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_cs_n"}, {31'd0, CS_N}, 32'd1);
    if (v.nbit == 16'd0) check({tag, "_cs_never_low"}, 32'(cs_low_cnt), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_bad;

    //          nbit   nw  w0             w1             sdo nrx r0             r1             txre status
    vecs[0] = '{16'd32, 1, 32'hA5A5_0F0F, 32'h0,         2,  1,  32'hA5A5_0F0F, 32'h0,         1,   32'h0020_0002};
    vecs[1] = '{16'd40, 2, 32'hDEAD_BEEF, 32'hFF00_0000, 1,  2,  32'hFFFF_FFFF, 32'h0000_00FF, 2,   32'h0028_0002};
    vecs[2] = '{16'd64, 1, 32'h1234_5678, 32'h0,         2,  1,  32'h1234_5678, 32'h0,         1,   32'h0020_0006};
    vecs[3] = '{16'd0,  0, 32'h0,         32'h0,         2,  0,  32'h0,         32'h0,         0,   32'h0000_0012};
    vecs[4] = '{16'd8,  1, 32'hC3FF_FFFF, 32'h0,         2,  1,  32'h0000_00C3, 32'h0,         1,   32'h0008_0002};
    vecs[5] = '{16'd1,  1, 32'h8000_0000, 32'h0,         2,  1,  32'h0000_0001, 32'h0,         1,   32'h0001_0002};
    vecs[6] = '{16'd33, 2, 32'h0F0F_0F0F, 32'h8000_0000, 2,  2,  32'h0F0F_0F0F, 32'h0000_0001, 2,   32'h0021_0002};

    // Reset state
    repeat (3) @(posedge CK);
    #1;
    check("rst_status", STATUS_WORD, 32'd0);
    check("rst_pins", {27'd0, SCLK, SDI, CS_N, TX_RE, RX_WE}, 32'b00100);
    check("rst_rx_data", RX_DATA, 32'd0);
    RESETb = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // RX FIFO full at the first STORE: clock must freeze low without losing bits
    tx_re_cnt = 0; rx_we_cnt = 0; sdo_mode = 2; stall_bad = 0;
    tx_q.push_back(32'h3C3C_9669); tx_q.push_back(32'h0123_4567);
    exp_q.push_back(32'h3C3C_9669); exp_q.push_back(32'h0123_4567);
    RX_FULL = 1'b1;
    repeat (2) @(posedge CK);
    #1;
    start_xfer(16'd64);
    wait_count("stall", 16'd32);
    repeat (20) begin
      @(posedge CK); #1;
      if (SCLK !== 1'b0 || RX_WE !== 1'b0) stall_bad++;
    end
    check("stall_sclk_low", 32'(stall_bad), 32'd0);
    check("stall_count", {16'd0, STATUS_WORD[31:16]}, 32'd32);
    RX_FULL = 1'b0;
    wait_idle("stall");
    check("stall_status", STATUS_WORD, 32'h0040_0002);
    check("stall_rx_we", 32'(rx_we_cnt), 32'd2);
    check("stall_pending", 32'(exp_q.size()), 32'd0);

    // ABORT at bit 10 of a 32-bit transfer: no RX write, aborted+done
    tx_re_cnt = 0; rx_we_cnt = 0; sdo_mode = 2;
    tx_q.push_back(32'h5555_AAAA);
    repeat (2) @(posedge CK);
    #1;
    start_xfer(16'd32);
    wait_count("abort", 16'd10);
    COMMAND[1] = 1'b1;
    @(posedge CK); #1;
    COMMAND[1] = 1'b0;
    wait_idle("abort");
    check("abort_status", STATUS_WORD, 32'h000A_000A);
    check("abort_rx_we", 32'(rx_we_cnt), 32'd0);
    check("abort_cs_n", {31'd0, CS_N}, 32'd1);

`ifdef TOFPET_CFG_LOOPBACK_EN
    // Loopback: SDO held low, RX must still equal TX
    tx_re_cnt = 0; rx_we_cnt = 0; sdo_mode = 0;
    COMMAND[2] = 1'b1;
    tx_q.push_back(32'h6B1D_E2C4);
    exp_q.push_back(32'h6B1D_E2C4);
    repeat (2) @(posedge CK);
    #1;
    start_xfer(16'd32);
    wait_idle("loopback");
    COMMAND[2] = 1'b0;
    check("loopback_rx_we", 32'(rx_we_cnt), 32'd1);
    check("loopback_status", STATUS_WORD, 32'h0020_0002);
`endif

    // Reset in the middle of a shift: outputs return to reset values at once
    sdo_mode = 2;
    tx_q.push_back(32'hF0F0_1234);
    repeat (2) @(posedge CK);
    #1;
    start_xfer(16'd32);
    wait_count("midrst", 16'd5);
    repeat (5) @(posedge CK);
    #1;
    RESETb = 1'b0;
    #1;
    check("midrst_status", STATUS_WORD, 32'd0);
    check("midrst_pins", {27'd0, SCLK, SDI, CS_N, TX_RE, RX_WE}, 32'b00100);
    check("midrst_rx_data", RX_DATA, 32'd0);
    @(posedge CK); #1;
    RESETb = 1'b1;
    tx_q.delete();

    // Recovery after reset
    run_vec(0, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
